// File: rtl/alu_pkg.sv
// Shared definitions for the execute-block ALU multiplier.
// Optional signed mode (MULT) is enabled by defining ALU_MUL_SIGNED_EN.
package alu_pkg;

  // Default operand width of the 8-bit MIPS datapath
  localparam int unsigned AluW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } mul_state_e;

  // 1-bit full-adder cell; returns {carry_out, sum}
  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    fa = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/addnb_ripple.sv
// W-bit ripple-carry adder built by chaining 1-bit full-adder cells.
module addnb_ripple
  import alu_pkg::*;
#(
  parameter int unsigned W = AluW
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_cell
    assign {c[i+1], s[i]} = fa(a[i], b[i], c[i]);
  end

  assign co = c[W];

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-and-add multiplier: one partial-product add per clock, W iterations,
// double-width HI/LO result. Define ALU_MUL_SIGNED_EN to add the sgn port (two's-complement
// operands handled by magnitude multiply plus final negation).
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned W  = AluW,
  parameter int unsigned CW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef ALU_MUL_SIGNED_EN
  input  logic         sgn,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  mul_state_e state_q, state_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  mplr_q, mplr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          neg_q, neg_d;

  logic [W-1:0]   op_a, op_b;
  logic           op_neg;
  logic [W-1:0]   addend, sum;
  logic           carry;
  logic [2*W-1:0] prod;

  // Operand conditioning at start: magnitudes and result sign in signed mode
  always_comb begin
`ifdef ALU_MUL_SIGNED_EN
    op_a   = (sgn && a[W-1]) ? (~a + W'(1)) : a;
    op_b   = (sgn && b[W-1]) ? (~b + W'(1)) : b;
    op_neg = sgn & (a[W-1] ^ b[W-1]);
`else
    op_a   = a;
    op_b   = b;
    op_neg = 1'b0;
`endif
  end

  assign addend = mplr_q[0] ? mcand_q : '0;

  addnb_ripple #(
    .W (W)
  ) u_add (
    .a  (acc_q),
    .b  (addend),
    .ci (1'b0),
    .s  (sum),
    .co (carry)
  );

  // Next-state: FSM, shift register, counter and result capture
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    prod    = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = op_a;
          acc_d   = '0;
          mplr_d  = op_b;
          cnt_d   = '0;
          neg_d   = op_neg;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // Shift {carry, sum, mplr} right by one
        acc_d  = {carry, sum[W-1:1]};
        mplr_d = {sum[0], mplr_q[W-1:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          // Capture on the final add so hi/lo are valid while done is high
          prod    = {acc_d, mplr_d};
          prod    = neg_q ? (~prod + (2*W)'(1)) : prod;
          hi_d    = prod[2*W-1:W];
          lo_d    = prod[W-1:0];
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
    end
  end

  assign busy = (state_q == StCalc);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq; covers signed mode when ALU_MUL_SIGNED_EN is defined.
module tb_alu_mul_seq;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst, start, sgn;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] hi, lo;

  int errors = 0;
  int checks = 0;

  // Results of the last run_mult
  int          r_busy, r_done_cyc, r_dones;
  logic        r_hold_ok;
  logic [15:0] r_prod;

  always #5 clk = ~clk;

  alu_mul_seq #(
    .W  (8),
    .CW (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef ALU_MUL_SIGNED_EN
    .sgn   (sgn),
`endif
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Start a multiply and observe W+5 cycles; optional extra start pulse in cycle inj_cyc
  task automatic run_mult(input logic [7:0] ia, input logic [7:0] ib, input logic isg,
                          input int inj_cyc, input logic [7:0] ja, input logic [7:0] jb);
    logic [15:0] prev;
    @(negedge clk);
    a = ia; b = ib; sgn = isg; start = 1'b1;
    prev = {hi, lo};
    r_busy = 0; r_done_cyc = 0; r_dones = 0; r_hold_ok = 1'b1; r_prod = 16'hxxxx;
    for (int i = 1; i <= W + 5; i++) begin
      @(posedge clk); #1;
      if (i == inj_cyc) begin
        a = ja; b = jb; start = 1'b1;
      end else begin
        // Operands are latched, so scramble them after the start cycle
        a = 8'h5A; b = 8'hC3; start = 1'b0;
      end
      if (busy) begin
        r_busy++;
        if ({hi, lo} !== prev) r_hold_ok = 1'b0;
      end
      if (done) begin
        r_dones++;
        if (r_done_cyc == 0) begin
          r_done_cyc = i;
          r_prod = {hi, lo};
        end
      end
    end
    sgn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; sgn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi !== 8'h00) begin errors++; $display("FAIL reset_hi got=%h exp=00", hi); end
    checks++; if (lo !== 8'h00) begin errors++; $display("FAIL reset_lo got=%h exp=00", lo); end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_mult(8'd13, 8'd11, 1'b0, 0, 8'h00, 8'h00);
    checks++; if (r_busy !== 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", r_busy); end
    checks++; if (r_done_cyc !== 9) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=9", r_done_cyc); end
    checks++; if (r_dones !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", r_dones); end
    checks++; if (r_hold_ok !== 1'b1) begin errors++; $display("FAIL basic_hold_while_busy got=%b exp=1", r_hold_ok); end
    checks++; if (r_prod !== 16'h008F) begin errors++; $display("FAIL basic_product got=%h exp=008f", r_prod); end
    checks++; if ({hi, lo} !== 16'h008F) begin errors++; $display("FAIL basic_hold_after got=%h exp=008f", {hi, lo}); end
  endtask

  task automatic test_max();
    run_mult(8'hFF, 8'hFF, 1'b0, 0, 8'h00, 8'h00);
    checks++; if (r_prod !== 16'hFE01) begin errors++; $display("FAIL max_product got=%h exp=fe01", r_prod); end
    checks++; if (r_hold_ok !== 1'b1) begin errors++; $display("FAIL max_hold_while_busy got=%b exp=1", r_hold_ok); end
  endtask

  task automatic test_zero();
    run_mult(8'h00, 8'hA5, 1'b0, 0, 8'h00, 8'h00);
    checks++; if (r_busy !== 8) begin errors++; $display("FAIL zero_busy_cycles got=%0d exp=8", r_busy); end
    checks++; if (r_done_cyc !== 9) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=9", r_done_cyc); end
    checks++; if (r_prod !== 16'h0000) begin errors++; $display("FAIL zero_product got=%h exp=0000", r_prod); end
  endtask

  task automatic test_start_ignored();
    run_mult(8'd3, 8'd5, 1'b0, 3, 8'd7, 8'd7);
    checks++; if (r_prod !== 16'h000F) begin errors++; $display("FAIL ignore_product got=%h exp=000f", r_prod); end
    checks++; if (r_dones !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", r_dones); end
    checks++; if (r_busy !== 8) begin errors++; $display("FAIL ignore_busy_cycles got=%0d exp=8", r_busy); end
  endtask

  task automatic test_rst_abort();
    int dones;
    @(negedge clk);
    a = 8'h80; b = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Now in CALC cycle 4
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if ({hi, lo} !== 16'h0000) begin errors++; $display("FAIL abort_hilo got=%h exp=0000", {hi, lo}); end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    // rst and start together: rst wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'h09; b = 8'h09;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_start_idle got=%b exp=0", busy); end
    run_mult(8'd2, 8'd2, 1'b0, 0, 8'h00, 8'h00);
    checks++; if (r_prod !== 16'h0004) begin errors++; $display("FAIL after_abort_product got=%h exp=0004", r_prod); end
    checks++; if (r_done_cyc !== 9) begin errors++; $display("FAIL after_abort_done_cycle got=%0d exp=9", r_done_cyc); end
  endtask

`ifdef ALU_MUL_SIGNED_EN
  task automatic test_signed();
    run_mult(8'hFD, 8'h05, 1'b1, 0, 8'h00, 8'h00);
    checks++; if (r_prod !== 16'hFFF1) begin errors++; $display("FAIL signed_neg got=%h exp=fff1", r_prod); end
    checks++; if (r_done_cyc !== 9) begin errors++; $display("FAIL signed_latency got=%0d exp=9", r_done_cyc); end
    run_mult(8'h80, 8'h80, 1'b1, 0, 8'h00, 8'h00);
    checks++; if (r_prod !== 16'h4000) begin errors++; $display("FAIL signed_minmin got=%h exp=4000", r_prod); end
    run_mult(8'h80, 8'h80, 1'b0, 0, 8'h00, 8'h00);
    checks++; if (r_prod !== 16'h4000) begin errors++; $display("FAIL unsigned_8080 got=%h exp=4000", r_prod); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_start_ignored();
    test_rst_abort();
`ifdef ALU_MUL_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
